// File: rtl/raster_pixel_arbiter.sv
// raster_pixel_arbiter
//    Lets NUM_PORTS rasterizer pixel streams share one frame-buffer/depth
//    write port. Arbitration is round-robin into a single registered output
//    slot. A requester that is not granted sees req_stall and holds its
//    pixel. The per-rasterizer done levels are combined into one frame-done.
//
// Ports
//    clock         system clock
//    reset         asynchronous, active-high reset
//    req_valid     per-port pixel valid
//    req_addr      per-port address, port i at [i*ADDR_W +: ADDR_W]
//    req_color     per-port color, packed the same way
//    req_depth     per-port 16.16 depth, packed the same way
//    req_done      per-port "triangle stream finished" level
//    req_stall     per-port stall, requester holds its pixel while high
//    addr_out      granted pixel address
//    color_out     granted pixel color
//    depth_out     granted pixel depth
//    output_valid  output slot holds a pixel
//    stall_in      downstream stall, output slot holds while high
//    done_out      all ports done and arbiter drained
module raster_pixel_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 26,
   parameter int COLOR_W   = 24,
   parameter int DEPTH_W   = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_PORTS-1:0]         req_valid,
   input  logic [NUM_PORTS*ADDR_W-1:0]  req_addr,
   input  logic [NUM_PORTS*COLOR_W-1:0] req_color,
   input  logic [NUM_PORTS*DEPTH_W-1:0] req_depth,
   input  logic [NUM_PORTS-1:0]         req_done,
   output logic [NUM_PORTS-1:0]         req_stall,
   output logic [ADDR_W-1:0]            addr_out,
   output logic [COLOR_W-1:0]           color_out,
   output logic [DEPTH_W-1:0]           depth_out,
   output logic                         output_valid,
   input  logic                         stall_in,
   output logic                         done_out
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [IDX_W-1:0]     last_grant;
   logic [IDX_W-1:0]     grant_idx;
   logic [NUM_PORTS-1:0] grant;
   logic                 any_grant;
   logic                 free;
   logic                 done_set;
   int                   cand;

   logic [ADDR_W-1:0]    mux_addr;
   logic [COLOR_W-1:0]   mux_color;
   logic [DEPTH_W-1:0]   mux_depth;

   assign free = !output_valid || !stall_in;

   // Search starts one past the last winner. The modulo keeps every
   // candidate inside 0..NUM_PORTS-1, including non-power-of-two counts.
   always_comb begin
      grant     = '0;
      grant_idx = last_grant;
      any_grant = 1'b0;
      cand      = 0;
      if (free) begin
         for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(last_grant) + k) % NUM_PORTS;
            if (!any_grant && req_valid[cand]) begin
               grant[cand] = 1'b1;
               grant_idx   = IDX_W'(cand);
               any_grant   = 1'b1;
            end
         end
      end
   end

   // Stall depends only on valids and slot state, never on pixel data.
   assign req_stall = req_valid & ~grant;

   // One-hot AND-OR mux; no variable part-select, so no out-of-range port.
   always_comb begin
      mux_addr  = '0;
      mux_color = '0;
      mux_depth = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant[i]) begin
            mux_addr  = mux_addr  | req_addr[i*ADDR_W +: ADDR_W];
            mux_color = mux_color | req_color[i*COLOR_W +: COLOR_W];
            mux_depth = mux_depth | req_depth[i*DEPTH_W +: DEPTH_W];
         end
      end
   end

   // A port still presenting a pixel is not considered done, whatever its
   // done level says. The slot must be empty or leaving this cycle.
   assign done_set = (&req_done) && !(|req_valid) && free;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         output_valid <= 1'b0;
         addr_out     <= '0;
         color_out    <= '0;
         depth_out    <= '0;
         last_grant   <= IDX_W'(NUM_PORTS - 1);
         done_out     <= 1'b0;
      end else begin
         if (any_grant) begin
            addr_out     <= mux_addr;
            color_out    <= mux_color;
            depth_out    <= mux_depth;
            output_valid <= 1'b1;
            last_grant   <= grant_idx;
         end else if (free) begin
            output_valid <= 1'b0;
         end
         // A new grant refills the slot, so done must drop with it.
         done_out <= done_set || (done_out && (&req_done) && !any_grant);
      end
   end

endmodule

// File: tb/tb_raster_pixel_arbiter.sv
module tb_raster_pixel_arbiter;

   logic        clock = 1'b0;
   logic        reset;

   // two-port instance
   logic [1:0]  req_valid;
   logic [51:0] req_addr;
   logic [47:0] req_color;
   logic [63:0] req_depth;
   logic [1:0]  req_done;
   logic [1:0]  req_stall;
   logic [25:0] addr_out;
   logic [23:0] color_out;
   logic [31:0] depth_out;
   logic        output_valid;
   logic        stall_in;
   logic        done_out;

   // three-port instance
   logic [2:0]  v3;
   logic [77:0] a3;
   logic [71:0] c3;
   logic [95:0] d3;
   logic [2:0]  done3_in;
   logic [2:0]  stall3;
   logic [25:0] addr3;
   logic [23:0] color3;
   logic [31:0] depth3;
   logic        ov3;
   logic        stall3_in;
   logic        done3;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [25:0] A0 = 26'h100;
   localparam logic [23:0] C0 = 24'hFF0000;
   localparam logic [31:0] D0 = 32'h0001_8000;
   localparam logic [25:0] A1 = 26'h2AB;
   localparam logic [23:0] C1 = 24'h00FF00;
   localparam logic [31:0] D1 = 32'h0002_4000;

   always #5 clock = ~clock;

   raster_pixel_arbiter #(.NUM_PORTS(2)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_color(req_color),
      .req_depth(req_depth), .req_done(req_done), .req_stall(req_stall),
      .addr_out(addr_out), .color_out(color_out), .depth_out(depth_out),
      .output_valid(output_valid), .stall_in(stall_in), .done_out(done_out)
   );

   raster_pixel_arbiter #(.NUM_PORTS(3)) dut3 (
      .clock(clock), .reset(reset),
      .req_valid(v3), .req_addr(a3), .req_color(c3),
      .req_depth(d3), .req_done(done3_in), .req_stall(stall3),
      .addr_out(addr3), .color_out(color3), .depth_out(depth3),
      .output_valid(ov3), .stall_in(stall3_in), .done_out(done3)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      req_valid = '0;
      req_done  = '0;
      stall_in  = 1'b0;
      v3        = '0;
      reset     = 1'b1;
      tick();
      reset     = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = '0;
      req_done  = '0;
      stall_in  = 1'b0;
      v3        = '0;
      reset     = 1'b1;
      tick();
      n_checks++;
      if (output_valid !== 1'b0 || done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got ov=%b done=%b, expected ov=0 done=0", output_valid, done_out);
      end
      n_checks++;
      if (addr_out !== 26'h0 || color_out !== 24'h0 || depth_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h/%h, expected all zero", addr_out, color_out, depth_out);
      end
      n_checks++;
      if (req_stall !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_stall: got %b, expected 00", req_stall);
      end
      reset = 1'b0;
   endtask

   task automatic test_single();
      apply_reset();
      req_valid = 2'b01;
      #1;
      n_checks++;
      if (req_stall !== 2'b00) begin
         n_fail++;
         $display("FAIL single_stall: got %b, expected 00", req_stall);
      end
      tick();
      req_valid = 2'b00;
      n_checks++;
      if (output_valid !== 1'b1 || addr_out !== A0 || color_out !== C0 || depth_out !== D0) begin
         n_fail++;
         $display("FAIL single_out: got ov=%b %h/%h/%h, expected ov=1 %h/%h/%h",
                  output_valid, addr_out, color_out, depth_out, A0, C0, D0);
      end
      tick();
      n_checks++;
      if (output_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_drain: got ov=%b, expected 0", output_valid);
      end
   endtask

   task automatic test_contention();
      logic [1:0]  exp_stall [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
      logic [25:0] exp_addr  [4] = '{A0, A1, A0, A1};
      logic [23:0] exp_color [4] = '{C0, C1, C0, C1};
      apply_reset();
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (req_stall !== exp_stall[i]) begin
            n_fail++;
            $display("FAIL contention_stall[%0d]: got %b, expected %b", i, req_stall, exp_stall[i]);
         end
         tick();
         n_checks++;
         if (output_valid !== 1'b1 || addr_out !== exp_addr[i] || color_out !== exp_color[i]) begin
            n_fail++;
            $display("FAIL contention_out[%0d]: got ov=%b %h/%h, expected ov=1 %h/%h",
                     i, output_valid, addr_out, color_out, exp_addr[i], exp_color[i]);
         end
      end
      req_valid = 2'b00;
   endtask

   task automatic test_downstream_stall();
      apply_reset();
      req_valid = 2'b01;
      tick();
      req_valid = 2'b10;
      stall_in  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (req_stall !== 2'b10) begin
            n_fail++;
            $display("FAIL dstall_stall[%0d]: got %b, expected 10", i, req_stall);
         end
         tick();
         n_checks++;
         if (output_valid !== 1'b1 || addr_out !== A0 || depth_out !== D0) begin
            n_fail++;
            $display("FAIL dstall_hold[%0d]: got ov=%b %h/%h, expected ov=1 %h/%h",
                     i, output_valid, addr_out, depth_out, A0, D0);
         end
      end
      stall_in = 1'b0;
      #1;
      n_checks++;
      if (req_stall !== 2'b00) begin
         n_fail++;
         $display("FAIL dstall_release_stall: got %b, expected 00", req_stall);
      end
      tick();
      req_valid = 2'b00;
      n_checks++;
      if (output_valid !== 1'b1 || addr_out !== A1 || color_out !== C1 || depth_out !== D1) begin
         n_fail++;
         $display("FAIL dstall_next: got ov=%b %h/%h/%h, expected ov=1 %h/%h/%h",
                  output_valid, addr_out, color_out, depth_out, A1, C1, D1);
      end
   endtask

   task automatic test_done();
      apply_reset();
      req_done = 2'b01;
      tick();
      n_checks++;
      if (done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL done_partial: got %b, expected 0", done_out);
      end
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      stall_in  = 1'b1;
      req_done  = 2'b11;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++;
         if (done_out !== 1'b0 || output_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pending[%0d]: got done=%b ov=%b, expected done=0 ov=1", i, done_out, output_valid);
         end
      end
      stall_in = 1'b0;
      tick();
      n_checks++;
      if (done_out !== 1'b1 || output_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL done_set: got done=%b ov=%b, expected done=1 ov=0", done_out, output_valid);
      end
      tick();
      n_checks++;
      if (done_out !== 1'b1) begin
         n_fail++;
         $display("FAIL done_hold: got %b, expected 1", done_out);
      end
      req_done = 2'b01;
      tick();
      n_checks++;
      if (done_out !== 1'b0) begin
         n_fail++;
         $display("FAIL done_clear: got %b, expected 0", done_out);
      end
      req_done = 2'b00;
   endtask

   task automatic test_async_reset();
      apply_reset();
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      stall_in  = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (output_valid !== 1'b0 || done_out !== 1'b0 || addr_out !== 26'h0) begin
         n_fail++;
         $display("FAIL async_reset: got ov=%b done=%b addr=%h, expected 0/0/0",
                  output_valid, done_out, addr_out);
      end
      #1;
      reset     = 1'b0;
      stall_in  = 1'b0;
      req_valid = 2'b11;
      #1;
      n_checks++;
      if (req_stall !== 2'b10) begin
         n_fail++;
         $display("FAIL async_first_stall: got %b, expected 10", req_stall);
      end
      tick();
      req_valid = 2'b00;
      n_checks++;
      if (output_valid !== 1'b1 || addr_out !== A0) begin
         n_fail++;
         $display("FAIL async_first_grant: got ov=%b addr=%h, expected ov=1 addr=%h", output_valid, addr_out, A0);
      end
   endtask

   task automatic test_three_ports();
      logic [2:0]  exp_stall [6] = '{3'b110, 3'b101, 3'b001, 3'b100, 3'b001, 3'b100};
      logic [25:0] exp_addr  [6] = '{26'h10, 26'h11, 26'h12, 26'h10, 26'h12, 26'h10};
      apply_reset();
      v3 = 3'b111;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_checks++;
         if (stall3 !== exp_stall[i]) begin
            n_fail++;
            $display("FAIL rr3_stall[%0d]: got %b, expected %b", i, stall3, exp_stall[i]);
         end
         tick();
         if (i == 1) v3 = 3'b101;
         n_checks++;
         if (ov3 !== 1'b1 || addr3 !== exp_addr[i]) begin
            n_fail++;
            $display("FAIL rr3_out[%0d]: got ov=%b addr=%h, expected ov=1 addr=%h", i, ov3, addr3, exp_addr[i]);
         end
      end
      v3 = 3'b000;
   endtask

   initial begin
      reset     = 1'b0;
      req_valid = '0;
      req_done  = '0;
      stall_in  = 1'b0;
      req_addr  = {A1, A0};
      req_color = {C1, C0};
      req_depth = {D1, D0};
      v3        = '0;
      done3_in  = '0;
      stall3_in = 1'b0;
      a3        = {26'h12, 26'h11, 26'h10};
      c3        = {24'h2, 24'h1, 24'h0};
      d3        = {32'h2, 32'h1, 32'h0};
      #2;
      test_reset();
      test_single();
      test_contention();
      test_downstream_stall();
      test_done();
      test_async_reset();
      test_three_ports();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
